fetch_unit: RTL and testbench



---
 rtl/fetch_unit_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 52 +++++
 rtl/fetch_unit.sv | 128 ++++++++++++
 tb/tb_fetch_unit.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared fetch-stage definitions
// Purpose: fetch FSM state encodings and the default reset PC.
// Ports: none (package).
package fetch_unit_pkg;

    // Two-bit encoding; the spare codes fall back to FS_FETCH.
    typedef enum logic [1:0] {
        FS_FETCH = 2'b00,
        FS_FLUSH = 2'b01
    } fetch_state_t;

    localparam int DEFAULT_RESET_PC = 0;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous instruction buffer for the fetch unit
// Purpose: small register FIFO holding {pc, instruction} words.
// Ports: clk, rst (sync, active-high); push/din write; pop advances head;
//        clear empties the buffer (wins over push); dout is the head word;
//        count is the occupancy; empty flags count == 0.
module fetch_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         clear,
    input  logic [W-1:0]                 din,
    output logic [W-1:0]                 dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push;

    // DEPTH is a power of two, so the pointers wrap modulo DEPTH naturally.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front-end with redirect flush
// Purpose: keeps the PC, issues in-order imem requests under a credit limit,
//          buffers returned words and hands them to decode; redirects flush.
// Ports: clk, rst (sync, active-high); imem_req_* request channel;
//        imem_resp_* in-order response channel; redirect_valid/redirect_pc
//        from execute; inst_valid/inst_ready/inst/inst_pc toward decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              IW       = 8,
    parameter int              AW       = 8,
    parameter int              DEPTH    = 2,
    parameter logic [AW-1:0]   RESET_PC = AW'(DEFAULT_RESET_PC)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          imem_req_valid,
    input  logic          imem_req_ready,
    output logic [AW-1:0] imem_req_addr,
    input  logic          imem_resp_valid,
    input  logic [IW-1:0] imem_resp_data,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [IW-1:0] inst,
    output logic [AW-1:0] inst_pc
);
    localparam int CW = $clog2(DEPTH+1);

    fetch_state_t   state, state_next;
    logic [AW-1:0]  pc, pc_next;
    logic [AW-1:0]  resp_pc, resp_pc_next;
    logic [AW-1:0]  target, target_next;
    logic [CW-1:0]  outstanding, outstanding_next;
    logic [CW-1:0]  fifo_count;
    logic [CW:0]    in_use;
    logic           req_fire;
    logic           resp_take;
    logic           fifo_push;
    logic           fifo_pop;
    logic           fifo_empty;
    logic [AW+IW-1:0] fifo_dout;

    // Credit: in-flight requests plus buffered words never exceed DEPTH,
    // so every response has a FIFO slot waiting for it.
    assign in_use         = {1'b0, outstanding} + {1'b0, fifo_count};
    assign imem_req_valid = !rst && (state == FS_FETCH) && !redirect_valid
                            && (in_use < (CW+1)'(DEPTH));
    assign imem_req_addr  = rst ? RESET_PC : pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses with nothing outstanding are stray and dropped.
    assign resp_take = imem_resp_valid && (outstanding != '0);
    assign fifo_push = resp_take && (state == FS_FETCH) && !redirect_valid;

    assign inst_valid = !rst && !fifo_empty;
    assign fifo_pop   = inst_valid && inst_ready;
    assign inst       = inst_valid ? fifo_dout[IW-1:0]     : '0;
    assign inst_pc    = inst_valid ? fifo_dout[AW+IW-1:IW] : '0;

    fetch_fifo #(
        .W     (AW + IW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .clear (redirect_valid),
        .din   ({resp_pc, imem_resp_data}),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    always_comb begin
        state_next       = state;
        pc_next          = pc;
        resp_pc_next     = resp_pc;
        target_next      = target;
        // Responses retire a credit in every state, even when discarded.
        outstanding_next = outstanding + CW'(req_fire) - CW'(resp_take);

        if (redirect_valid) begin
            target_next = redirect_pc;
            if (outstanding_next == '0) begin
                state_next   = FS_FETCH;
                pc_next      = redirect_pc;
                resp_pc_next = redirect_pc;
            end else begin
                state_next = FS_FLUSH;
            end
        end else begin
            case (state)
                FS_FETCH: begin
                    if (req_fire)  pc_next      = pc + AW'(1);
                    if (resp_take) resp_pc_next = resp_pc + AW'(1);
                end
                FS_FLUSH: begin
                    if (outstanding_next == '0) begin
                        state_next   = FS_FETCH;
                        pc_next      = target;
                        resp_pc_next = target;
                    end
                end
                default: state_next = FS_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FS_FETCH;
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            target      <= RESET_PC;
            outstanding <= '0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            resp_pc     <= resp_pc_next;
            target      <= target_next;
            outstanding <= outstanding_next;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;
    localparam int IW = 8;
    localparam int AW = 8;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          imem_req_valid;
    logic          imem_req_ready = 1'b1;
    logic [AW-1:0] imem_req_addr;
    logic          imem_resp_valid = 1'b0;
    logic [IW-1:0] imem_resp_data = '0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          inst_valid;
    logic          inst_ready = 1'b0;
    logic [IW-1:0] inst;
    logic [AW-1:0] inst_pc;

    logic          req_valid2;
    logic [AW-1:0] req_addr2;
    logic          resp_valid2 = 1'b0;
    logic [IW-1:0] resp_data2 = '0;
    logic          inst_valid2;
    logic [IW-1:0] inst2;
    logic [AW-1:0] inst_pc2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_unit #(.IW(IW), .AW(AW), .DEPTH(DEPTH), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc)
    );

    fetch_unit #(.IW(IW), .AW(AW), .DEPTH(DEPTH), .RESET_PC(8'hFE)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_valid2), .imem_req_ready(1'b1),
        .imem_req_addr(req_addr2),
        .imem_resp_valid(resp_valid2), .imem_resp_data(resp_data2),
        .redirect_valid(1'b0), .redirect_pc(8'h00),
        .inst_valid(inst_valid2), .inst_ready(1'b1),
        .inst(inst2), .inst_pc(inst_pc2)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Memory model for the main instance: mem[a] = a ^ A5, in-order,
    // latency mem_lat edges after acceptance, optional toggling ready.
    typedef struct {
        logic [AW-1:0] addr;
        int unsigned   due;
    } pend_t;

    pend_t         pend_q[$];
    int unsigned   edge_n = 0;
    int            mem_lat = 1;
    bit            ready_toggle = 1'b0;
    int            req_count = 0;
    bit            prev_stall = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    always @(posedge clk) edge_n <= edge_n + 1;

    initial begin
        pend_t p;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend_q.delete();
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && !redirect_valid)
                    check("req_hold", {imem_req_valid, imem_req_addr}, {1'b1, prev_addr});
                if (imem_resp_valid && pend_q.size() > 0)
                    void'(pend_q.pop_front());
                if (imem_req_valid && imem_req_ready) begin
                    p.addr = imem_req_addr;
                    p.due  = edge_n + 1 + mem_lat;
                    pend_q.push_back(p);
                    req_count++;
                end
                check("outstanding_bound", pend_q.size() <= DEPTH, 1);
                prev_stall = imem_req_valid && !imem_req_ready;
                prev_addr  = imem_req_addr;
            end
            @(posedge clk);
            #1;
            imem_req_ready = ready_toggle ? ~imem_req_ready : 1'b1;
            if (pend_q.size() > 0 && pend_q[0].due <= edge_n + 1) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = pend_q[0].addr ^ 8'hA5;
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = '0;
            end
        end
    end

    // Scoreboard monitor for the main instance.
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] exp_head;
    int delivered = 0;
    int since_rst = 0;
    int first_valid = -1;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                since_rst   = 0;
                first_valid = -1;
            end else begin
                if (inst_valid && first_valid < 0) first_valid = since_rst;
                since_rst++;
                if (inst_valid && inst_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_inst: got pc %0h expected none", inst_pc);
                    end else begin
                        exp_head = exp_q.pop_front();
                        check("inst_pc", inst_pc, exp_head);
                        check("inst", inst, exp_head ^ 8'hA5);
                    end
                    delivered++;
                end
            end
        end
    end

    // Wrap instance: 1-cycle memory, always ready, decode always ready.
    logic          fire2 = 1'b0;
    logic [AW-1:0] addr2 = '0;
    logic [AW-1:0] exp2 [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    int            idx2 = 0;

    initial begin
        forever begin
            @(negedge clk);
            fire2 = req_valid2 && !rst;
            addr2 = req_addr2;
            @(posedge clk);
            #1;
            resp_valid2 = fire2;
            resp_data2  = addr2 ^ 8'hA5;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                idx2 = 0;
            end else if (inst_valid2) begin
                if (idx2 < 4) begin
                    check("wrap_pc", inst_pc2, exp2[idx2]);
                    check("wrap_inst", inst2, exp2[idx2] ^ 8'hA5);
                end
                idx2++;
            end
        end
    end

    task automatic do_reset();
        rst            = 1'b1;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        delivered = 0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input logic [AW-1:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + AW'(i));
    endtask

    task automatic wait_delivered(input int n, input int bound, input string name);
        int c;
        c = 0;
        while (delivered < n && c < bound) begin
            @(posedge clk);
            #1;
            c++;
        end
        inst_ready = 1'b0;
        check({name, "_delivered"}, delivered, n);
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values while rst is held.
        @(negedge clk);
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_inst", inst, 0);
        check("rst_inst_pc", inst_pc, 0);
        check("rst_req_addr", imem_req_addr, 0);

        // Streaming, 1-cycle memory.
        mem_lat = 1; ready_toggle = 1'b0;
        do_reset();
        inst_ready = 1'b1;
        push_seq(8'h00, 8);
        @(negedge clk);
        check("post_rst_req_valid", imem_req_valid, 1);
        check("post_rst_req_addr", imem_req_addr, 0);
        wait_delivered(8, 100, "stream");
        check("first_valid_latency", first_valid, 2);

        // Decode stalled: exactly DEPTH requests, buffer holds 00 then 01.
        do_reset();
        req_count = 0;
        cycles(10);
        @(negedge clk);
        check("stall_req_count", req_count, DEPTH);
        check("stall_req_valid", imem_req_valid, 0);
        check("stall_inst_valid", inst_valid, 1);
        check("stall_inst_pc", inst_pc, 8'h00);
        check("stall_inst", inst, 8'hA5);
        push_seq(8'h00, 6);
        @(posedge clk);
        #1;
        inst_ready = 1'b1;
        wait_delivered(6, 100, "release");

        // Toggling ready with 3-cycle latency.
        mem_lat = 3; ready_toggle = 1'b1;
        do_reset();
        inst_ready = 1'b1;
        push_seq(8'h00, 8);
        wait_delivered(8, 300, "toggle");
        ready_toggle = 1'b0;

        // Redirect with two requests in flight goes through FLUSH.
        mem_lat = 3;
        do_reset();
        inst_ready = 1'b1;
        push_seq(8'h40, 2);
        cycles(2);
        redirect_valid = 1'b1; redirect_pc = 8'h40;
        cycles(1);
        redirect_valid = 1'b0;
        @(negedge clk);
        check("flush_req_valid", imem_req_valid, 0);
        check("flush_inst_valid", inst_valid, 0);
        wait_delivered(2, 100, "flush");

        // Redirect with one buffered word popped in the same cycle.
        mem_lat = 1;
        do_reset();
        inst_ready = 1'b1;
        exp_q.push_back(8'h00);
        push_seq(8'h40, 3);
        cycles(2);
        redirect_valid = 1'b1; redirect_pc = 8'h40;
        cycles(1);
        redirect_valid = 1'b0;
        @(negedge clk);
        check("redir_inst_valid", inst_valid, 0);
        check("redir_pop_once", delivered, 1);
        check("redir_req_valid", imem_req_valid, 1);
        check("redir_req_addr", imem_req_addr, 8'h40);
        wait_delivered(4, 100, "redir");

        // Back-to-back redirects while flushing: last target wins.
        mem_lat = 3;
        do_reset();
        inst_ready = 1'b1;
        push_seq(8'h20, 3);
        cycles(2);
        redirect_valid = 1'b1; redirect_pc = 8'h10;
        cycles(1);
        redirect_pc = 8'h20;
        cycles(1);
        redirect_valid = 1'b0;
        wait_delivered(3, 100, "b2b");

        // Reset asserted mid-FLUSH.
        mem_lat = 3;
        do_reset();
        inst_ready = 1'b1;
        cycles(2);
        redirect_valid = 1'b1; redirect_pc = 8'h30;
        cycles(1);
        redirect_valid = 1'b0;
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_inst_valid", inst_valid, 0);
        check("midrst_inst", inst, 0);
        check("midrst_inst_pc", inst_pc, 0);
        check("midrst_req_valid", imem_req_valid, 1);
        check("midrst_req_addr", imem_req_addr, 8'h00);
        push_seq(8'h00, 3);
        wait_delivered(3, 100, "midrst");

        check("wrap_seen", idx2 >= 4, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
